// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sub_fullsub.sv
// One-bit full subtractor: difference and borrow-out.
module fullsub (
  output logic D,
  output logic Bo,
  input  logic A,
  input  logic B,
  input  logic Bi
);

  assign D  = A ^ B ^ Bi;
  assign Bo = (~A & B) | (~(A ^ B) & Bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: LSB-first over WIDTH cycles, result
// registered on entry to DONE, done pulse one cycle later.
import serial_sub_pkg::*;

module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d_bit;
  logic             b_next;
  logic [WIDTH-1:0] res_next;

  fullsub u_fs (
    .D  (d_bit),
    .Bo (b_next),
    .A  (a_sr[0]),
    .B  (b_sr[0]),
    .Bi (bin)
  );

  assign res_next = {d_bit, res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      cnt   <= '0;
      bin   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      D     <= '0;
      Bout  <= 1'b0;
      V     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          bin  <= b_next;
          res  <= res_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            // a_sr[0]/b_sr[0] now hold the operand sign bits
            D     <= res_next;
            Bout  <= b_next;
            V     <= (a_sr[0] != b_sr[0]) && (d_bit != a_sr[0]);
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
